// File: rtl/usb_ep_fifo_bank.sv
`timescale 1ns/1ps
// usb_ep_fifo_bank: per-endpoint IN/OUT byte FIFOs for bulk endpoints, with DATA0/1
// tracking. A packet is committed only on a successful transaction; otherwise it is rolled back.
module usb_ep_fifo_bank #(
  parameter int N_EP       = 2,
  parameter int DEPTH_LOG2 = 7,
  parameter int MAX_PKT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usb_rst,
  input  logic [3:0]        endpoint,
  input  logic              transaction_active,
  input  logic              direction_in,
  input  logic              setup,
  input  logic              data_strobe,
  input  logic              success,
  input  logic [7:0]        data_out,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic [1:0]        handshake,
  output logic              data_toggle,
  input  logic [N_EP-1:0]   in_wr_en,
  input  logic [8*N_EP-1:0] in_wr_data,
  output logic [N_EP-1:0]   in_full,
  input  logic [N_EP-1:0]   out_rd_en,
  output logic [8*N_EP-1:0] out_rd_data,
  output logic [N_EP-1:0]   out_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EPW   = (N_EP > 1) ? $clog2(N_EP) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [2:0] {S_IDLE, S_IN, S_OUT, S_STALL, S_FIN} state_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t MAX_P   = ptr_t'(MAX_PKT);
  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  state_t          state;
  logic [EPW-1:0]  ep;
  ptr_t            shadow, cnt, bcnt;
  logic            ovf;
  logic [N_EP-1:0] toggle_in, toggle_out;

  ptr_t in_wr  [N_EP];
  ptr_t in_rd  [N_EP];
  ptr_t out_wr [N_EP];
  ptr_t out_rd [N_EP];
  ptr_t in_wr_nxt  [N_EP];
  ptr_t in_rd_nxt  [N_EP];
  ptr_t out_wr_nxt [N_EP];
  ptr_t out_rd_nxt [N_EP];

  logic [7:0] in_mem  [N_EP][DEPTH];
  logic [7:0] out_mem [N_EP][DEPTH];

  logic [EPW-1:0] tok_ep;
  logic           tok_bad;
  ptr_t           tok_level, tok_cnt, tok_free;
  logic           in_strobe, out_write, commit_in, commit_out;

  // Token decode uses committed pointers; the shadow pointer only exists for the latched endpoint.
  always_comb begin
    tok_ep     = endpoint[EPW-1:0];
    tok_bad    = setup || (endpoint >= 4'(N_EP));
    tok_level  = in_wr[tok_ep] - in_rd[tok_ep];
    tok_cnt    = (tok_level > MAX_P) ? MAX_P : tok_level;
    tok_free   = DEPTH_P - (out_wr[tok_ep] - out_rd[tok_ep]);
    in_strobe  = (state == S_IN) && transaction_active && data_strobe && (cnt != '0);
    out_write  = (state == S_OUT) && transaction_active && data_strobe &&
                 (handshake == HS_ACK) && (bcnt < MAX_P);
    commit_in  = (state == S_IN) && !transaction_active && success && (handshake == HS_ACK);
    commit_out = (state == S_OUT) && !transaction_active && success &&
                 (handshake == HS_ACK) && !ovf;
    for (int i = 0; i < N_EP; i++) begin
      in_wr_nxt[i]  = in_wr[i];
      out_rd_nxt[i] = out_rd[i];
      if (in_wr_en[i] && !in_full[i])
        in_wr_nxt[i] = in_wr[i] + ptr_t'(1);
      if (out_rd_en[i] && !out_empty[i])
        out_rd_nxt[i] = out_rd[i] + ptr_t'(1);
      in_rd_nxt[i]  = (commit_in && (ep == EPW'(i))) ? shadow : in_rd[i];
      out_wr_nxt[i] = (commit_out && (ep == EPW'(i))) ? shadow : out_wr[i];
    end
  end

  always_comb begin
    data_in     = (state == S_IN) ? in_mem[ep][shadow[DEPTH_LOG2-1:0]] : 8'h00;
    out_rd_data = '0;
    for (int i = 0; i < N_EP; i++)
      out_rd_data[8*i +: 8] = out_mem[i][out_rd[i][DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EP; i++)
      if (in_wr_en[i] && !in_full[i])
        in_mem[i][in_wr[i][DEPTH_LOG2-1:0]] <= in_wr_data[8*i +: 8];
    if (out_write)
      out_mem[ep][shadow[DEPTH_LOG2-1:0]] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst || usb_rst) begin
      state         <= S_IDLE;
      ep            <= '0;
      shadow        <= '0;
      cnt           <= '0;
      bcnt          <= '0;
      ovf           <= 1'b0;
      handshake     <= HS_NAK;
      data_in_valid <= 1'b0;
      data_toggle   <= 1'b0;
      toggle_in     <= '0;
      toggle_out    <= '0;
      in_full       <= '0;
      out_empty     <= '1;
      for (int i = 0; i < N_EP; i++) begin
        in_wr[i]  <= '0;
        in_rd[i]  <= '0;
        out_wr[i] <= '0;
        out_rd[i] <= '0;
      end
    end else begin
      // Flags come from next-state pointers so they are exact for the following cycle.
      for (int i = 0; i < N_EP; i++) begin
        in_wr[i]     <= in_wr_nxt[i];
        in_rd[i]     <= in_rd_nxt[i];
        out_wr[i]    <= out_wr_nxt[i];
        out_rd[i]    <= out_rd_nxt[i];
        in_full[i]   <= (in_wr_nxt[i] - in_rd_nxt[i]) == DEPTH_P;
        out_empty[i] <= (out_wr_nxt[i] == out_rd_nxt[i]);
      end
      if (commit_in)
        toggle_in[ep] <= ~toggle_in[ep];
      if (commit_out)
        toggle_out[ep] <= ~toggle_out[ep];

      case (state)
        S_IDLE: begin
          if (transaction_active) begin
            ep   <= tok_ep;
            bcnt <= '0;
            ovf  <= 1'b0;
            if (tok_bad) begin
              state         <= S_STALL;
              handshake     <= HS_STALL;
              data_in_valid <= 1'b0;
            end else if (direction_in) begin
              state         <= S_IN;
              shadow        <= in_rd[tok_ep];
              cnt           <= tok_cnt;
              handshake     <= (tok_cnt == '0) ? HS_NAK : HS_ACK;
              data_in_valid <= (tok_cnt != '0);
              data_toggle   <= toggle_in[tok_ep];
            end else begin
              state         <= S_OUT;
              shadow        <= out_wr[tok_ep];
              cnt           <= '0;
              handshake     <= (tok_free < MAX_P) ? HS_NAK : HS_ACK;
              data_in_valid <= 1'b0;
              data_toggle   <= toggle_out[tok_ep];
            end
          end
        end
        S_IN: begin
          if (!transaction_active) begin
            state         <= S_FIN;
            data_in_valid <= 1'b0;
          end else if (in_strobe) begin
            shadow <= shadow + ptr_t'(1);
            cnt    <= cnt - ptr_t'(1);
            if (cnt == ptr_t'(1))
              data_in_valid <= 1'b0;
          end
        end
        S_OUT: begin
          if (!transaction_active)
            state <= S_FIN;
          else if (data_strobe && (handshake == HS_ACK)) begin
            if (bcnt < MAX_P) begin
              shadow <= shadow + ptr_t'(1);
              bcnt   <= bcnt + ptr_t'(1);
            end else
              ovf <= 1'b1;
          end
        end
        S_STALL: begin
          if (!transaction_active)
            state <= S_FIN;
        end
        S_FIN: begin
          state         <= S_IDLE;
          data_in_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_ep_fifo_bank.sv
`timescale 1ns/1ps
// Self-checking bench for usb_ep_fifo_bank: byte scoreboards per direction plus a
// small toggle/occupancy model predict handshakes, data and flags.
module tb_usb_ep_fifo_bank;
  localparam int N_EP       = 2;
  localparam int DEPTH_LOG2 = 7;
  localparam int MAX_PKT    = 64;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic usb_rst = 1'b0;
  logic [3:0] endpoint = '0;
  logic transaction_active = 1'b0;
  logic direction_in = 1'b0;
  logic setup = 1'b0;
  logic data_strobe = 1'b0;
  logic success = 1'b0;
  logic [7:0] data_out = '0;
  logic [7:0] data_in;
  logic data_in_valid;
  logic [1:0] handshake;
  logic data_toggle;
  logic [N_EP-1:0] in_wr_en = '0;
  logic [8*N_EP-1:0] in_wr_data = '0;
  logic [N_EP-1:0] in_full;
  logic [N_EP-1:0] out_rd_en = '0;
  logic [8*N_EP-1:0] out_rd_data;
  logic [N_EP-1:0] out_empty;

  int checks = 0;
  int errors = 0;
  logic [7:0] inQ[$];
  logic [7:0] outQ[$];
  logic [1:0] togIn = '0;
  logic [1:0] togOut = '0;

  usb_ep_fifo_bank #(.N_EP(N_EP), .DEPTH_LOG2(DEPTH_LOG2), .MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .rst(rst), .usb_rst(usb_rst), .endpoint(endpoint),
    .transaction_active(transaction_active), .direction_in(direction_in), .setup(setup),
    .data_strobe(data_strobe), .success(success), .data_out(data_out), .data_in(data_in),
    .data_in_valid(data_in_valid), .handshake(handshake), .data_toggle(data_toggle),
    .in_wr_en(in_wr_en), .in_wr_data(in_wr_data), .in_full(in_full),
    .out_rd_en(out_rd_en), .out_rd_data(out_rd_data), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ep, input logic dir, input logic stp);
    endpoint = ep;
    direction_in = dir;
    setup = stp;
    transaction_active = 1'b1;
    tick;
  endtask

  task automatic endTxn(input logic s);
    success = s;
    transaction_active = 1'b0;
    tick;
    success = 1'b0;
    setup = 1'b0;
    tick;
  endtask

  task automatic pushIn(input logic [7:0] b);
    in_wr_en = 2'b10;
    in_wr_data = {b, 8'h00};
    if (inQ.size() < DEPTH) inQ.push_back(b);
    tick;
    in_wr_en = '0;
    checkOutput("in_full_push", in_full[1], inQ.size() == DEPTH);
  endtask

  task automatic inTxn(input int ep, input logic s);
    int level = (ep == 1) ? inQ.size() : 0;
    int expn = (level > MAX_PKT) ? MAX_PKT : level;
    int got = 0;
    logic [7:0] dump;
    applyStimulus(4'(ep), 1'b1, 1'b0);
    checkOutput("in_hs", handshake, (expn == 0) ? 2'b10 : 2'b00);
    checkOutput("in_toggle", data_toggle, togIn[ep]);
    while (data_in_valid && got < MAX_PKT + 4) begin
      if (got < expn) checkOutput("in_byte", data_in, inQ[got]);
      else checkOutput("in_extra_byte", got, expn);
      data_strobe = 1'b1;
      got++;
      tick;
    end
    data_strobe = 1'b0;
    checkOutput("in_count", got, expn);
    endTxn(s);
    if (s && expn > 0) begin
      for (int k = 0; k < expn; k++) dump = inQ.pop_front();
      togIn[ep] = ~togIn[ep];
    end
    checkOutput("in_full_after", in_full[1], inQ.size() == DEPTH);
  endtask

  task automatic outTxn(input int n, input logic s, input logic [7:0] base);
    int used = outQ.size();
    logic [1:0] hs = ((DEPTH - used) < MAX_PKT) ? 2'b10 : 2'b00;
    logic [7:0] pkt[$];
    applyStimulus(4'd0, 1'b0, 1'b0);
    checkOutput("out_hs", handshake, hs);
    checkOutput("out_toggle", data_toggle, togOut[0]);
    for (int k = 0; k < n; k++) begin
      data_out = base + 8'(k);
      pkt.push_back(data_out);
      data_strobe = 1'b1;
      tick;
    end
    data_strobe = 1'b0;
    endTxn(s);
    if (s && hs == 2'b00 && n <= MAX_PKT) begin
      foreach (pkt[k]) outQ.push_back(pkt[k]);
      togOut[0] = ~togOut[0];
    end
    checkOutput("out_empty_after", out_empty[0], outQ.size() == 0);
  endtask

  task automatic popOut;
    logic [7:0] exp;
    while (outQ.size() > 0) begin
      exp = outQ.pop_front();
      checkOutput("out_not_empty", out_empty[0], 1'b0);
      checkOutput("out_byte", out_rd_data[7:0], exp);
      out_rd_en = 2'b01;
      tick;
      out_rd_en = '0;
    end
    checkOutput("out_drained", out_empty[0], 1'b1);
  endtask

  task automatic stallTxn(input logic [3:0] ep, input logic dir, input logic stp);
    applyStimulus(ep, dir, stp);
    checkOutput("stall_hs", handshake, 2'b11);
    checkOutput("stall_dv", data_in_valid, 1'b0);
    endTxn(1'b1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hs"}, handshake, 2'b10);
    checkOutput({tag, "_dv"}, data_in_valid, 1'b0);
    checkOutput({tag, "_toggle"}, data_toggle, 1'b0);
    checkOutput({tag, "_data_in"}, data_in, 8'h00);
    checkOutput({tag, "_in_full"}, in_full, 2'b00);
    checkOutput({tag, "_out_empty"}, out_empty, 2'b11);
  endtask

  initial begin
    repeat (2) tick;
    rst = 1'b0;
    tick;
    checkResetState("reset");

    for (int k = 0; k < 5; k++) pushIn(8'hA0 + 8'(k));
    inTxn(1, 1'b1);
    inTxn(1, 1'b1);
    for (int k = 0; k < 5; k++) pushIn(8'hA0 + 8'(k));
    inTxn(1, 1'b0);
    inTxn(1, 1'b1);
    inTxn(0, 1'b1);

    outTxn(64, 1'b1, 8'h10);
    popOut;
    outTxn(64, 1'b0, 8'h55);
    outTxn(70, 1'b1, 8'h80);
    outTxn(4, 1'b1, 8'hC0);
    popOut;

    outTxn(64, 1'b1, 8'h20);
    outTxn(1, 1'b1, 8'h99);
    outTxn(8, 1'b1, 8'hEE);
    popOut;

    pushIn(8'h5A);
    pushIn(8'hA5);
    stallTxn(4'd1, 1'b1, 1'b1);
    stallTxn(4'd2, 1'b1, 1'b0);
    stallTxn(4'd15, 1'b0, 1'b0);
    inTxn(1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH + 1; k++) pushIn(8'($urandom));
      inTxn(1, 1'b1);
      inTxn(1, 1'b1);
    end

    outTxn(4, 1'b1, 8'h30);
    usb_rst = 1'b1;
    tick;
    usb_rst = 1'b0;
    tick;
    outQ.delete();
    inQ.delete();
    togIn = '0;
    togOut = '0;
    checkResetState("usb_rst");

    for (int k = 0; k < 3; k++) pushIn(8'h70 + 8'(k));
    applyStimulus(4'd1, 1'b1, 1'b0);
    data_strobe = 1'b1;
    tick;
    data_strobe = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    transaction_active = 1'b0;
    tick;
    inQ.delete();
    togIn = '0;
    togOut = '0;
    checkResetState("mid_rst");
    inTxn(1, 1'b1);
    pushIn(8'h3C);
    pushIn(8'hC3);
    inTxn(1, 1'b1);
    outTxn(2, 1'b1, 8'h44);
    popOut;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
